// File: rtl/vga_sync_if.sv
// Timing bundle from the VGA sync generator to the pixel/character renderer.
interface vga_sync_if;
  logic       p_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;

  modport master (
    output p_tick, hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );
  modport slave (
    input  p_tick, hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator on the master clock: pixel-enable prescaler, h/v counters,
// registered sync/blank/coordinate outputs and one-clock line/frame pulses.
module vga_sync_gen #(
  parameter int unsigned PIX_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  vga_sync_if.master vga
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned PCW     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [PCW-1:0] PC_LAST  = PCW'(PIX_DIV - 1);
  localparam logic [9:0]     H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]     V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]     H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]     V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]     HS_FIRST = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0]     HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0]     VS_FIRST = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0]     VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [PCW-1:0] pc;
  logic [9:0]     h, v;
  logic [9:0]     h_nxt, v_nxt;
  logic           tick;
  logic           hsync_r, vsync_r, video_r;

  assign tick = (pc == PC_LAST);

  always_comb begin
    h_nxt = h;
    v_nxt = v;
    if (tick) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h_nxt = h + 10'd1;
      end
    end
  end

  // Sync/blank decode from the next-state counters so they switch on the same edge as h/v.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= '0;
      h       <= '0;
      v       <= '0;
      hsync_r <= ~SYNC_POL;
      vsync_r <= ~SYNC_POL;
      video_r <= 1'b0;
    end else begin
      pc      <= tick ? '0 : pc + PCW'(1);
      h       <= h_nxt;
      v       <= v_nxt;
      hsync_r <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vsync_r <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      video_r <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end
  end

  assign vga.p_tick      = tick && rst_n;
  assign vga.line_start  = vga.p_tick && (h == '0);
  assign vga.frame_start = vga.p_tick && (h == '0) && (v == '0);
  assign vga.hsync       = hsync_r;
  assign vga.vsync       = vsync_r;
  assign vga.video_on    = video_r;
  assign vga.pixel_x     = h;
  assign vga.pixel_y     = v;

endmodule
